// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, load/store and memory-side signals of the
// two-port memory arbiter.
//   fetch:  f_req, f_addr -> ; <- f_rdata, f_ready
//   lsu:    l_req, l_we, l_addr, l_wdata -> ; <- l_rdata, l_ready
//   memory: <- mem_req, mem_we, mem_addr, mem_wdata ; mem_rdata, mem_ready ->
//   status: <- owner (0 = fetch, 1 = LSU), err (sticky timeout)
// slave  : arbiter view (drives grants, memory command and status)
// master : environment view (requesters plus memory)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_ready;

  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [DATA_WIDTH-1:0] l_rdata;
  logic                  l_ready;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic                  owner;
  logic                  err;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata, mem_ready,
    output f_rdata, f_ready, l_rdata, l_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, owner, err
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata, mem_ready,
    input  f_rdata, f_ready, l_rdata, l_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, owner, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetch unit and
// the load/store unit. Round-robin grant in IDLE, transaction held in BUSY
// until mem_ready or watchdog expiry, one-cycle ready pulse in DONE.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   bus  - mem_arbiter_if.slave (requester handshakes, memory port, owner, err)
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (0 disables the watchdog).
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] f_rdata_q;
  logic [DATA_WIDTH-1:0] l_rdata_q;
  logic                  f_ready_q;
  logic                  l_ready_q;
  logic                  owner_q;
  logic                  err_q;
  logic [WD_W-1:0]       wdog_q;

  logic grant_l;
  logic timeout_hit;

  // On a tie the requester that did not hold the port last time wins.
  assign grant_l     = bus.l_req && (!bus.f_req || !owner_q);
  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      l_rdata_q   <= '0;
      f_ready_q   <= 1'b0;
      l_ready_q   <= 1'b0;
      owner_q     <= 1'b1;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.f_req || bus.l_req) begin
            if (grant_l) begin
              mem_addr_q  <= bus.l_addr;
              mem_we_q    <= bus.l_we;
              mem_wdata_q <= bus.l_wdata;
            end else begin
              mem_addr_q  <= bus.f_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
            owner_q   <= grant_l;
            mem_req_q <= 1'b1;
            wdog_q    <= '0;
            state_q   <= BUSY;
          end
        end

        BUSY: begin
          if (bus.mem_ready || timeout_hit) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            // Read data only on a real memory answer to a read; the ready
            // pulse is dropped if the owner withdrew its request meanwhile.
            if (owner_q) begin
              l_ready_q <= bus.l_req;
              if (bus.mem_ready && !mem_we_q) l_rdata_q <= bus.mem_rdata;
            end else begin
              f_ready_q <= bus.f_req;
              if (bus.mem_ready) f_rdata_q <= bus.mem_rdata;
            end
            if (!bus.mem_ready) err_q <= 1'b1;
            state_q <= DONE;
          end else if (wdog_q != '1) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        DONE: begin
          f_ready_q <= 1'b0;
          l_ready_q <= 1'b0;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.f_ready   = f_ready_q;
  assign bus.l_ready   = l_ready_q;
  assign bus.owner     = owner_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Expected read data is
// queued per requester when a transaction is started and popped by a monitor
// when the matching ready pulse appears.
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] fq[$];
  logic [7:0] lq[$];
  logic [7:0] l_last = 8'h00;
  logic f_prev = 1'b0;
  logic l_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every ready pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus.f_ready) begin
      if (f_prev) check("f_ready_width", 32'(f_prev), 32'd0);
      if (fq.size() == 0) check("f_ready_spurious", 32'(bus.f_ready), 32'd0);
      else begin
        check("f_rdata", 32'(bus.f_rdata), 32'(fq.pop_front()));
        check("f_owner", 32'(bus.owner), 32'd0);
      end
    end
    if (bus.l_ready) begin
      if (l_prev) check("l_ready_width", 32'(l_prev), 32'd0);
      if (lq.size() == 0) check("l_ready_spurious", 32'(bus.l_ready), 32'd0);
      else begin
        check("l_rdata", 32'(bus.l_rdata), 32'(lq.pop_front()));
        check("l_owner", 32'(bus.owner), 32'd1);
      end
    end
    f_prev = bus.f_ready;
    l_prev = bus.l_ready;
  end

  // Plays the memory: waits (bounded) for a grant, checks the command each
  // cycle, answers after lat cycles. Returns at the negedge of the DONE cycle.
  task automatic serve(input int lat, input logic [7:0] rd, input logic [7:0] ea,
                       input logic ewe, input logic [7:0] ewd, input string tag);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant_wait"}, 32'(n <= 2), 32'd1);
    for (int i = 0; i < lat; i++) begin
      check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(ea));
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(ewe));
      if (ewe) check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(ewd));
      if (i == lat - 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    check({tag, "_mem_req_done"}, 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    int cnt;
    bus.f_req = 1'b1; bus.f_addr = 8'h11;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h22; bus.l_wdata = 8'h00;
    bus.mem_ready = 1'b0; bus.mem_rdata = 8'h00;

    // Reset with both requests high
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_f_ready", 32'(bus.f_ready), 32'd0);
    check("rst_l_ready", 32'(bus.l_ready), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("first_grant_addr", 32'(bus.mem_addr), 32'h11);
    check("first_grant_owner", 32'(bus.owner), 32'd0);
    bus.l_req = 1'b0;
    fq.push_back(8'h5A);
    serve(1, 8'h5A, 8'h11, 1'b0, 8'h00, "rst_fetch");
    bus.f_req = 1'b0;
    @(negedge clk);

    // Single fetch, memory answers after 2 cycles
    bus.f_req = 1'b1; bus.f_addr = 8'h12;
    fq.push_back(8'hA5);
    serve(2, 8'hA5, 8'h12, 1'b0, 8'h00, "fetch");
    bus.f_req = 1'b0;
    @(negedge clk);

    // Store leaves l_rdata unchanged
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 8'h40; bus.l_wdata = 8'h3C;
    lq.push_back(l_last);
    serve(2, 8'hEE, 8'h40, 1'b1, 8'h3C, "store");
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    @(negedge clk);
    check("store_l_rdata_kept", 32'(bus.l_rdata), 32'(l_last));

    // Load
    bus.l_req = 1'b1; bus.l_addr = 8'h41;
    l_last = 8'h96;
    lq.push_back(l_last);
    serve(1, 8'h96, 8'h41, 1'b0, 8'h00, "load");
    bus.l_req = 1'b0;
    @(negedge clk);

    // Contention: owner is LSU now, so fetch wins first, then alternate
    bus.f_req = 1'b1; bus.f_addr = 8'h50;
    bus.l_req = 1'b1; bus.l_addr = 8'h60;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'h70 + 8'(k);
      if ((k % 2) == 0) begin
        fq.push_back(d);
        serve(1, d, 8'h50, 1'b0, 8'h00, "rr_f");
      end else begin
        l_last = d;
        lq.push_back(d);
        serve(1, d, 8'h60, 1'b0, 8'h00, "rr_l");
      end
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);

    // Fetch withdraws during BUSY: no f_ready
    bus.f_req = 1'b1; bus.f_addr = 8'h77;
    cnt = 0;
    while (bus.mem_req !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_grant", 32'(bus.mem_req), 32'd1);
    bus.f_req = 1'b0;
    @(negedge clk);
    check("abort_mem_req_held", 32'(bus.mem_req), 32'd1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 8'h33;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("abort_no_f_ready", 32'(bus.f_ready), 32'd0);
    check("abort_mem_req_low", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 8'h78;
    fq.push_back(8'hC3);
    serve(1, 8'hC3, 8'h78, 1'b0, 8'h00, "after_abort");
    bus.f_req = 1'b0;
    @(negedge clk);

    // Timeout: memory never answers, mem_req high TIMEOUT+1 cycles
    bus.l_req = 1'b1; bus.l_addr = 8'h90;
    lq.push_back(l_last);
    cnt = 0;
    while (bus.mem_req !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(cnt), 32'(TO + 1));
    check("timeout_err", 32'(bus.err), 32'd1);
    bus.l_req = 1'b0;
    @(negedge clk);
    bus.l_req = 1'b1; bus.l_addr = 8'h91;
    l_last = 8'h5E;
    lq.push_back(l_last);
    serve(1, 8'h5E, 8'h91, 1'b0, 8'h00, "post_timeout");
    bus.l_req = 1'b0;
    @(negedge clk);
    check("err_sticky", 32'(bus.err), 32'd1);

    // Reset in the middle of a transaction
    bus.f_req = 1'b1; bus.f_addr = 8'hAB;
    cnt = 0;
    while (bus.mem_req !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b0;
    bus.f_req = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_owner", 32'(bus.owner), 32'd1);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_f_rdata", 32'(bus.f_rdata), 32'd0);
    check("midrst_l_rdata", 32'(bus.l_rdata), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("f_queue_drained", 32'(fq.size()), 32'd0);
    check("l_queue_drained", 32'(lq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end
endmodule
